// File: rtl/multicycle_sched_if.sv
// Handshake and configuration bundle for multicycle_sched.
//   slave  : scheduler side (drives stage enables, in_ready, out_valid, cfg_err, busy)
//   master : requester/consumer/config side
interface multicycle_sched_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_load;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             synch_en;
    logic             decode_en;
    logic             mult_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  cfg_div, cfg_load, in_valid, out_ready,
        output cfg_err, in_ready, shift_en, synch_en, decode_en, mult_en, out_valid, busy
    );

    modport master (
        output cfg_div, cfg_load, in_valid, out_ready,
        input  cfg_err, in_ready, shift_en, synch_en, decode_en, mult_en, out_valid, busy
    );
endinterface

// File: rtl/multicycle_sched.sv
// multicycle_sched: single-clock sequencer for the shift -> synch -> decode -> multiply
// datapath. Issues one-cycle stage enables; the synch and decode stages are held for
// D = div_reg cycles so the logic between stages behaves as a D-cycle multicycle path.
// Ports:
//   fast_clk : sole clock, all state on posedge
//   rst      : asynchronous reset, active-high
//   bus      : multicycle_sched_if.slave (config, in/out handshakes, stage enables, busy)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operation, config writes accepted
// SHIFT | shift_en pulse
// SYNC  | synch_en on entry, held D cycles
// DEC   | decode_en on entry, held D cycles
// MUL   | mult_en pulse
// DONE  | out_valid held until out_ready
module multicycle_sched #(
    parameter int CNT_W   = 4,
    parameter int DEF_DIV = 4
) (
    input  logic                 fast_clk,
    input  logic                 rst,
    multicycle_sched_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, SYNC, DEC, MUL, DONE} state_t;

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;
    logic             in_ready_i;
    logic             shift_i, synch_i, decode_i, mult_i, out_valid_i, busy_i;
    logic             cfg_err_q;

    assign cnt_zero = (cnt == '0);
    assign accept   = bus.in_valid & in_ready_i;

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   state_nxt = SYNC;
            SYNC:    if (cnt_zero) state_nxt = DEC;
            DEC:     if (cnt_zero) state_nxt = MUL;
            MUL:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Entry cycle of SYNC/DEC is the only cycle the counter still holds div_reg-1,
    // since div_reg is frozen while busy and D >= 2 keeps entry and exit distinct.
    always_comb begin
        in_ready_i  = 1'b0;
        shift_i     = 1'b0;
        synch_i     = 1'b0;
        decode_i    = 1'b0;
        mult_i      = 1'b0;
        out_valid_i = 1'b0;
        busy_i      = (state != IDLE);
        case (state)
            IDLE:    in_ready_i  = ~rst;
            SHIFT:   shift_i     = 1'b1;
            SYNC:    synch_i     = (cnt == div_reg - ONE);
            DEC:     decode_i    = (cnt == div_reg - ONE);
            MUL:     mult_i      = 1'b1;
            DONE: begin
                out_valid_i = 1'b1;
                in_ready_i  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Wait counter: loaded on SYNC/DEC entry, saturates at zero.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state_nxt == SYNC && state != SYNC) ||
                     (state_nxt == DEC  && state != DEC)) begin
            cnt <= div_reg - ONE;
        end else if (!cnt_zero) begin
            cnt <= cnt - ONE;
        end
    end

    // Ratio register only moves in IDLE, so an in-flight op keeps its D.
    // A load in the accept cycle lands before SYNC entry and so applies to that op.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            div_reg   <= DEF;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (bus.cfg_load) begin
                if (state == IDLE && bus.cfg_div >= TWO) begin
                    div_reg <= bus.cfg_div;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.shift_en  = shift_i;
    assign bus.synch_en  = synch_i;
    assign bus.decode_en = decode_i;
    assign bus.mult_en   = mult_i;
    assign bus.out_valid = out_valid_i;
    assign bus.busy      = busy_i;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_multicycle_sched.sv
// Testbench for multicycle_sched: directed stimulus with a per-cycle schedule model
// (stage times derived from the accept cycle and the op's D) plus literal timing checks.
module tb_multicycle_sched;
    localparam int CNT_W   = 4;
    localparam int DEF_DIV = 4;

    logic fast_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 fast_clk = ~fast_clk;

    multicycle_sched_if #(.CNT_W(CNT_W)) bus ();

    multicycle_sched #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .fast_clk (fast_clk),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    bit op_on    = 0;
    int op_acc   = 0;
    int op_d     = DEF_DIV;
    int d_reg    = DEF_DIV;
    bit err_pend = 0;

    // observed event times
    int t_acc, t_shift, t_synch, t_dec, t_mult, t_ov;
    int n_err = 0;
    int n_overlap = 0;
    int mult_q[$];
    bit prev_ov = 0;
    int ne;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [7:0] got_v, exp_v;
        int rel;
        bit e_ov, e_ir;
        got_v = {bus.in_ready, bus.shift_en, bus.synch_en, bus.decode_en,
                 bus.mult_en, bus.out_valid, bus.busy, bus.cfg_err};
        if (rst) begin
            exp_v    = '0;
            op_on    = 0;
            d_reg    = DEF_DIV;
            err_pend = 0;
        end else begin
            rel  = cyc - op_acc;
            e_ov = op_on && (rel >= 3 + 2*op_d);
            e_ir = !op_on || (e_ov && bus.out_ready);
            exp_v = {e_ir, op_on && rel == 1, op_on && rel == 2, op_on && rel == 2 + op_d,
                     op_on && rel == 2 + 2*op_d, e_ov, op_on, err_pend};
            err_pend = bus.cfg_load && (op_on || int'(bus.cfg_div) < 2);
            if (!op_on && bus.cfg_load && int'(bus.cfg_div) >= 2) d_reg = int'(bus.cfg_div);
            if (e_ov && bus.out_ready) op_on = 0;
            if (bus.in_valid && e_ir) begin
                op_on  = 1;
                op_acc = cyc;
                op_d   = d_reg;
            end
        end
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_outputs: got %b expected %b (in_ready,shift,synch,decode,mult,out_valid,busy,cfg_err) cycle %0d",
                     got_v, exp_v, cyc);
        end
        if (bus.shift_en)  t_shift = cyc;
        if (bus.synch_en)  t_synch = cyc;
        if (bus.decode_en) t_dec   = cyc;
        if (bus.mult_en) begin
            t_mult = cyc;
            mult_q.push_back(cyc);
        end
        if (bus.out_valid && !prev_ov) t_ov = cyc;
        prev_ov = bus.out_valid;
        if (bus.cfg_err) n_err++;
        if ($countones({bus.shift_en, bus.synch_en, bus.decode_en, bus.mult_en}) > 1) n_overlap++;
    endtask

    task automatic step();
        @(negedge fast_clk);
        model_check();
        @(posedge fast_clk);
        cyc++;
        #1;
    endtask

    function automatic bit sig(input int which);
        return (which == 0) ? bus.out_valid : bus.decode_en;
    endfunction

    task automatic wait_for(input int which, input int max, input string name);
        int n = 0;
        while (!sig(which) && n < max) begin
            step();
            n++;
        end
        chk(name, int'(sig(which)), 1);
    endtask

    task automatic start_op();
        bus.in_valid = 1'b1;
        t_acc = cyc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
    endtask

    initial begin
        bus.cfg_div   = '0;
        bus.cfg_load  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // 1: default D=4 latency, out_valid held while stalled
        start_op();
        wait_for(0, 40, "t1_ov_timeout");
        repeat (3) step();
        chk("t1_ov_held", int'(bus.out_valid), 1);
        chk("t1_shift", t_shift - t_acc, 1);
        chk("t1_synch", t_synch - t_acc, 2);
        chk("t1_decode", t_dec - t_acc, 6);
        chk("t1_mult", t_mult - t_acc, 10);
        chk("t1_ov", t_ov - t_acc, 11);
        consume();

        // 2: D=7 loaded in IDLE
        ne = n_err;
        bus.cfg_div = 4'd7; bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        start_op();
        wait_for(0, 40, "t2_ov_timeout");
        step();
        chk("t2_synch_to_dec", t_dec - t_synch, 7);
        chk("t2_dec_to_mult", t_mult - t_dec, 7);
        chk("t2_no_cfg_err", n_err - ne, 0);
        consume();

        // 3: illegal D rejected, load during DEC rejected
        rst = 1'b1; step(); rst = 1'b0;
        ne = n_err;
        bus.cfg_div = 4'd1; bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        step();
        chk("t3_err_small", n_err - ne, 1);
        start_op();
        wait_for(1, 40, "t3_dec_timeout");
        bus.cfg_div = 4'd9; bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        wait_for(0, 40, "t3_ov_timeout");
        step();
        chk("t3_synch_to_dec", t_dec - t_synch, 4);
        chk("t3_dec_to_mult", t_mult - t_dec, 4);
        chk("t3_err_busy", n_err - ne, 2);
        consume();

        // 4: D=2 back-to-back
        bus.cfg_div = 4'd2; bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        mult_q.delete();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (30) step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        bus.out_ready = 1'b0;
        chk("t4_op_count", mult_q.size(), 5);
        for (int i = 0; i + 1 < mult_q.size(); i++)
            chk("t4_period", mult_q[i+1] - mult_q[i], 7);

        // 5: reset in the cycle after decode_en
        start_op();
        wait_for(1, 40, "t5_dec_timeout");
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_enables", int'({bus.shift_en, bus.synch_en, bus.decode_en, bus.mult_en}), 0);
        chk("t5_ov", int'(bus.out_valid), 0);
        chk("t5_in_ready", int'(bus.in_ready), 0);
        step(); step();
        rst = 1'b0;
        start_op();
        wait_for(0, 40, "t5_ov_timeout");
        step();
        chk("t5_synch_to_dec", t_dec - t_synch, DEF_DIV);
        chk("t5_dec_to_mult", t_mult - t_dec, DEF_DIV);
        consume();

        // 6: maximum D=15
        bus.cfg_div = 4'd15; bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        start_op();
        wait_for(0, 60, "t6_ov_timeout");
        step();
        chk("t6_synch_to_dec", t_dec - t_synch, 15);
        chk("t6_dec_to_mult", t_mult - t_dec, 15);
        chk("t6_ov", t_ov - t_acc, 33);
        consume();
        chk("no_enable_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
